// File: rtl/accel_pkg.sv
// accel_pkg: shared accelerator constants and the output writer state type.
package accel_pkg;
    localparam int MEM_BW        = 128;
    localparam int IO_DATA_WIDTH = 8;
    localparam int LANES         = MEM_BW / IO_DATA_WIDTH;
    localparam int ADDR_WIDTH    = 12;
    localparam int CNT_WIDTH     = 12;
    localparam int FIFO_DEPTH    = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} wr_state_e;
endpackage

// File: rtl/output_writer_if.sv
// output_writer_if: packed-word input stream plus SRAM write port.
interface output_writer_if #(
    parameter int DW = accel_pkg::MEM_BW,
    parameter int AW = accel_pkg::ADDR_WIDTH
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    modport master (input in_data, in_valid, mem_ready, output in_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (output in_data, in_valid, mem_ready, input in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/fifo_sync.sv
// fifo_sync: pointer-based synchronous FIFO with registered storage and a
// head-of-queue view; the extra pointer bit separates full from empty.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             do_push, do_pop;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = wr_q == rd_q;
    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // storage is cleared on reset so the head reads zero until the first push
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
            wr_q <= wr_q + (AW+1)'(do_push);
            rd_q <= rd_q + (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/output_writer.sv
// output_writer: buffers packed output words and writes them to consecutive
// SRAM addresses from a latched base, pulsing done after the last write.
module output_writer #(
    parameter int MEM_BW     = accel_pkg::MEM_BW,
    parameter int ADDR_WIDTH = accel_pkg::ADDR_WIDTH,
    parameter int CNT_WIDTH  = accel_pkg::CNT_WIDTH,
    parameter int FIFO_DEPTH = accel_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  arst_n_in,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    output_writer_if.master       bus
);
    import accel_pkg::*;
    wr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d, acc_q, acc_d, wr_q, wr_d;
    logic                  push, pop, full, empty;
    logic [MEM_BW-1:0]     head;
    fifo_sync #(.WIDTH(MEM_BW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .arst_n_in(arst_n_in),
        .push_i   (push),
        .pop_i    (pop),
        .data_i   (bus.in_data),
        .head_o   (head),
        .full_o   (full),
        .empty_o  (empty)
    );
    assign bus.in_ready  = (state_q == RUN) && !full && (acc_q < num_q);
    assign bus.mem_we    = (state_q == RUN) && !empty;
    assign bus.mem_addr  = base_q + ADDR_WIDTH'(wr_q);
    assign bus.mem_wdata = head;
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.mem_we && bus.mem_ready;
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    // finishing on the incremented count puts done in the cycle after the last write
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_d   = num_q;
        acc_d   = acc_q + CNT_WIDTH'(push);
        wr_d    = wr_q + CNT_WIDTH'(pop);
        case (state_q)
            IDLE: if (start) begin
                base_d  = base_addr;
                num_d   = num_words;
                acc_d   = '0;
                wr_d    = '0;
                state_d = num_words == '0 ? DONE : RUN;
            end
            RUN:     state_d = wr_d == num_q ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q <= IDLE;
            base_q  <= '0;
            num_q   <= '0;
            acc_q   <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
        end
    end
endmodule
